// File: rtl/tile_load_pkg.sv
// tile_load_pkg
// Shared types and constants for the tile load sequencer.
//   tile_load_state_t      : sequencer state (IDLE, LOAD, READY)
//   KERNEL_SEL_BIT         : a-word bit that routes a word to kernel memory
//   DEF_*                  : default stream and address widths
package tile_load_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } tile_load_state_t;

   localparam int KERNEL_SEL_BIT        = 15;
   localparam int DEF_IO_DATA_WIDTH     = 16;
   localparam int DEF_INPUT_ADDR_WIDTH  = 15;
   localparam int DEF_KERNEL_ADDR_WIDTH = 9;

endpackage

// File: rtl/sat_word_counter.sv
// sat_word_counter
// Word counter that stops at a programmable target.
//   clk, rst_n    : clock, synchronous active-low reset
//   clear         : zero the count (takes priority over inc)
//   inc           : count one word
//   target        : value at which counting stops
//   count         : current count
//   at_target     : count equals target
//   overflow_hit  : inc requested while already at target (count holds)
module sat_word_counter
   import tile_load_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] count,
   output logic             at_target,
   output logic             overflow_hit
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign at_target    = (count_q == target);
   assign overflow_hit = inc & at_target;
   assign count        = count_q;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && !at_target) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tile_load_ctrl.sv
// tile_load_ctrl
// Loads one convolution tile (input and kernel words) from the paired a/b
// streams into the input and kernel memories, then holds data_ready until
// the compute side reports completion.
//   clk, arst_n_in            : clock, synchronous active-low reset
//   load_start                : start pulse (IDLE only); latches word targets
//   nb_input_words/_kernel_   : number of words of each class to load
//   a_input/a_valid/a_ready   : address stream (bit 15 selects kernel memory)
//   b_input/b_valid/b_ready   : data stream, consumed together with a
//   mem_write_addr, mem_din   : shared memory write address/data
//   input_mem_we/kernel_mem_we: write strobes, combinational from the fire
//   data_ready                : tile loaded (level, READY state)
//   compute_done              : releases the tile (READY only)
//   busy                      : not IDLE
//   load_err                  : sticky; out-of-range kernel or extra word
`ifndef REG
`define REG(q, d, rv) \
   always_ff @(posedge clk) begin \
      if (!arst_n_in) q <= rv; \
      else q <= d; \
   end
`endif

module tile_load_ctrl
   import tile_load_pkg::*;
#(
   parameter int IO_DATA_WIDTH     = DEF_IO_DATA_WIDTH,
   parameter int INPUT_ADDR_WIDTH  = DEF_INPUT_ADDR_WIDTH,
   parameter int KERNEL_ADDR_WIDTH = DEF_KERNEL_ADDR_WIDTH
) (
   input  logic                        clk,
   input  logic                        arst_n_in,
   input  logic                        load_start,
   input  logic [INPUT_ADDR_WIDTH:0]   nb_input_words,
   input  logic [KERNEL_ADDR_WIDTH:0]  nb_kernel_words,
   input  logic [IO_DATA_WIDTH-1:0]    a_input,
   input  logic                        a_valid,
   output logic                        a_ready,
   input  logic [IO_DATA_WIDTH-1:0]    b_input,
   input  logic                        b_valid,
   output logic                        b_ready,
   output logic [INPUT_ADDR_WIDTH-1:0] mem_write_addr,
   output logic [IO_DATA_WIDTH-1:0]    mem_din,
   output logic                        input_mem_we,
   output logic                        kernel_mem_we,
   output logic                        data_ready,
   input  logic                        compute_done,
   output logic                        busy,
   output logic                        load_err
);

   localparam int IN_CW = INPUT_ADDR_WIDTH + 1;
   localparam int K_CW  = KERNEL_ADDR_WIDTH + 1;

   tile_load_state_t state_q, state_d;
   logic [IN_CW-1:0] in_tgt_q, in_tgt_d;
   logic [K_CW-1:0]  k_tgt_q, k_tgt_d;
   logic             load_err_q, load_err_d;

   logic             in_load, fire, start_ok;
   logic             is_kernel, k_in_range;
   logic             in_inc, k_inc, k_oor;
   logic [IN_CW-1:0] in_count;
   logic [K_CW-1:0]  k_count;
   logic             in_at, k_at, in_ovf, k_ovf;
   logic             in_done_next, k_done_next;

   assign in_load    = (state_q == ST_LOAD);
   assign start_ok   = (state_q == ST_IDLE) && load_start;
   assign fire       = a_valid & b_valid & a_ready & b_ready;
   assign is_kernel  = a_input[KERNEL_SEL_BIT];
   // Kernel addresses must fit the kernel memory; higher bits must be zero.
   assign k_in_range = (a_input[INPUT_ADDR_WIDTH-1:KERNEL_ADDR_WIDTH] == '0);
   assign in_inc     = fire & ~is_kernel;
   assign k_inc      = fire & is_kernel & k_in_range;
   assign k_oor      = fire & is_kernel & ~k_in_range;

   assign a_ready        = in_load;
   assign b_ready        = in_load;
   assign mem_write_addr = a_input[INPUT_ADDR_WIDTH-1:0];
   assign mem_din        = b_input;
   assign input_mem_we   = in_inc;
   assign kernel_mem_we  = k_inc;
   assign data_ready     = (state_q == ST_READY);
   assign busy           = (state_q != ST_IDLE);
   assign load_err       = load_err_q;

   sat_word_counter #(.WIDTH(IN_CW)) u_in_cnt (
      .clk          (clk),
      .rst_n        (arst_n_in),
      .clear        (start_ok),
      .inc          (in_inc),
      .target       (in_tgt_q),
      .count        (in_count),
      .at_target    (in_at),
      .overflow_hit (in_ovf)
   );

   sat_word_counter #(.WIDTH(K_CW)) u_k_cnt (
      .clk          (clk),
      .rst_n        (arst_n_in),
      .clear        (start_ok),
      .inc          (k_inc),
      .target       (k_tgt_q),
      .count        (k_count),
      .at_target    (k_at),
      .overflow_hit (k_ovf)
   );

   // Look one edge ahead so the completing fire moves straight to READY.
   assign in_done_next = in_at | (in_inc && ((in_count + IN_CW'(1)) == in_tgt_q));
   assign k_done_next  = k_at  | (k_inc  && ((k_count  + K_CW'(1))  == k_tgt_q));

   always_comb begin
      state_d    = state_q;
      in_tgt_d   = in_tgt_q;
      k_tgt_d    = k_tgt_q;
      load_err_d = load_err_q;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               in_tgt_d   = nb_input_words;
               k_tgt_d    = nb_kernel_words;
               load_err_d = 1'b0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_ovf || k_ovf || k_oor) begin
               load_err_d = 1'b1;
            end
            if (in_done_next && k_done_next) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (compute_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   `REG(state_q, state_d, ST_IDLE)
   `REG(in_tgt_q, in_tgt_d, '0)
   `REG(k_tgt_q, k_tgt_d, '0)
   `REG(load_err_q, load_err_d, 1'b0)

endmodule

// File: tb/tb_tile_load_ctrl.sv
module tb_tile_load_ctrl;

   logic        clk = 1'b0;
   logic        arst_n_in;
   logic        load_start;
   logic [15:0] nb_input_words;
   logic [9:0]  nb_kernel_words;
   logic [15:0] a_input;
   logic        a_valid;
   logic        a_ready;
   logic [15:0] b_input;
   logic        b_valid;
   logic        b_ready;
   logic [14:0] mem_write_addr;
   logic [15:0] mem_din;
   logic        input_mem_we;
   logic        kernel_mem_we;
   logic        data_ready;
   logic        compute_done;
   logic        busy;
   logic        load_err;

   always #5 clk = ~clk;

   tile_load_ctrl dut (
      .clk             (clk),
      .arst_n_in       (arst_n_in),
      .load_start      (load_start),
      .nb_input_words  (nb_input_words),
      .nb_kernel_words (nb_kernel_words),
      .a_input         (a_input),
      .a_valid         (a_valid),
      .a_ready         (a_ready),
      .b_input         (b_input),
      .b_valid         (b_valid),
      .b_ready         (b_ready),
      .mem_write_addr  (mem_write_addr),
      .mem_din         (mem_din),
      .input_mem_we    (input_mem_we),
      .kernel_mem_we   (kernel_mem_we),
      .data_ready      (data_ready),
      .compute_done    (compute_done),
      .busy            (busy),
      .load_err        (load_err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 0;
   int cyc      = 0;

   // Behavioural model: phase 0 idle, 1 loading, 2 tile ready.
   int m_phase  = 0;
   int m_in_cnt = 0;
   int m_k_cnt  = 0;
   int m_in_tgt = 0;
   int m_k_tgt  = 0;
   bit m_err    = 0;

   always @(posedge clk) begin
      cyc++;
      if (!arst_n_in) begin
         m_phase = 0; m_in_cnt = 0; m_k_cnt = 0;
         m_in_tgt = 0; m_k_tgt = 0; m_err = 0;
      end else begin
         case (m_phase)
            0: if (load_start) begin
               m_in_tgt = int'(nb_input_words);
               m_k_tgt  = int'(nb_kernel_words);
               m_in_cnt = 0; m_k_cnt = 0; m_err = 0;
               m_phase  = 1;
            end
            1: begin
               if (a_valid && b_valid) begin
                  if (a_input[15]) begin
                     if (a_input[14:9] != 6'd0) m_err = 1;
                     else if (m_k_cnt == m_k_tgt) m_err = 1;
                     else m_k_cnt++;
                  end else begin
                     if (m_in_cnt == m_in_tgt) m_err = 1;
                     else m_in_cnt++;
                  end
               end
               if (m_in_cnt == m_in_tgt && m_k_cnt == m_k_tgt) m_phase = 2;
            end
            default: if (compute_done) m_phase = 0;
         endcase
      end
   end

   // Observed write pulses (for the literal per-test expectations).
   int          in_we_n = 0;
   int          k_we_n  = 0;
   logic [14:0] in_addrs[$];
   logic [14:0] k_addrs[$];

   always @(negedge clk) begin
      logic [6:0] act, exp;
      bit ld, fire;
      if (checking) begin
         ld   = (m_phase == 1);
         fire = ld && a_valid && b_valid;
         exp  = {ld, ld, fire && !a_input[15],
                 fire && a_input[15] && (a_input[14:9] == 6'd0),
                 m_phase == 2, m_phase != 0, m_err};
         act  = {a_ready, b_ready, input_mem_we, kernel_mem_we, data_ready, busy, load_err};
         n_checks++;
         if (act !== exp || mem_write_addr !== a_input[14:0] || mem_din !== b_input) begin
            n_fail++;
            $display("FAIL cycle_model cyc=%0d: rdyA,rdyB,iwe,kwe,drdy,busy,err got %b want %b; addr %h/%h din %h/%h",
                     cyc, act, exp, mem_write_addr, a_input[14:0], mem_din, b_input);
         end
         if (input_mem_we === 1'b1) begin in_we_n++; in_addrs.push_back(mem_write_addr); end
         if (kernel_mem_we === 1'b1) begin k_we_n++; k_addrs.push_back(mem_write_addr); end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_log();
      in_we_n = 0; k_we_n = 0;
      in_addrs.delete(); k_addrs.delete();
   endtask

   task automatic start(input int ni, input int nk);
      nb_input_words  = 16'(ni);
      nb_kernel_words = 10'(nk);
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      $display("start targets in=%0d k=%0d busy=%0b", ni, nk, busy);
   endtask

   task automatic fire(input logic [15:0] a, input logic [15:0] b);
      a_input = a; b_input = b;
      a_valid = 1'b1; b_valid = 1'b1;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      $display("fire a=%h b=%h -> drdy=%0b err=%0b", a, b, data_ready, load_err);
   endtask

   task automatic finish_tile();
      compute_done = 1'b1;
      step();
      compute_done = 1'b0;
      $display("compute_done -> busy=%0b drdy=%0b", busy, data_ready);
   endtask

   initial begin
      arst_n_in = 1'b0; load_start = 1'b0; compute_done = 1'b0;
      nb_input_words = '0; nb_kernel_words = '0;
      a_input = '0; b_input = '0; a_valid = 1'b0; b_valid = 1'b0;
      step();
      checking = 1;
      step();
      chk("reset_busy", {31'd0, busy}, 0);
      chk("reset_ready", {30'd0, a_ready, b_ready}, 0);
      chk("reset_drdy_err", {30'd0, data_ready, load_err}, 0);
      arst_n_in = 1'b1;
      step();

      // T1: 4 input + 2 kernel words back to back.
      clr_log();
      start(4, 2);
      chk("t1_busy_after_start", {31'd0, busy}, 1);
      chk("t1_ready_after_start", {31'd0, a_ready}, 1);
      for (int i = 0; i < 4; i++) fire(16'(i), 16'h1000 + 16'(i));
      fire(16'h8000, 16'hA000);
      chk("t1_drdy_before_last", {31'd0, data_ready}, 0);
      fire(16'h8001, 16'hA001);
      chk("t1_drdy", {31'd0, data_ready}, 1);
      chk("t1_rdy_low", {31'd0, a_ready}, 0);
      chk("t1_err", {31'd0, load_err}, 0);
      chk("t1_in_we", in_we_n, 4);
      chk("t1_k_we", k_we_n, 2);
      for (int i = 0; i < 4; i++)
         if (i < in_addrs.size()) chk($sformatf("t1_in_addr%0d", i), {17'd0, in_addrs[i]}, i);
      for (int i = 0; i < 2; i++)
         if (i < k_addrs.size()) chk($sformatf("t1_k_addr%0d", i), {17'd0, k_addrs[i]}, i);
      finish_tile();
      chk("t1_idle", {30'd0, busy, data_ready}, 0);

      // T2: b stalls 3 cycles with a valid.
      clr_log();
      start(4, 2);
      fire(16'h0000, 16'h0); fire(16'h0001, 16'h1);
      a_input = 16'h0002; a_valid = 1'b1; b_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         $display("stall %0d iwe_total=%0d", i, in_we_n);
      end
      a_valid = 1'b0;
      chk("t2_stall_no_we", in_we_n, 2);
      chk("t2_stall_drdy", {31'd0, data_ready}, 0);
      fire(16'h0002, 16'h2); fire(16'h0003, 16'h3);
      fire(16'h8000, 16'h4); fire(16'h8001, 16'h5);
      chk("t2_drdy", {31'd0, data_ready}, 1);
      chk("t2_err", {31'd0, load_err}, 0);
      chk("t2_we_total", in_we_n + k_we_n, 6);
      finish_tile();

      // T3: out-of-range kernel address.
      clr_log();
      start(1, 1);
      fire(16'h0005, 16'h55);
      fire(16'h8400, 16'h66);
      chk("t3_oor_err", {31'd0, load_err}, 1);
      chk("t3_oor_no_we", k_we_n, 0);
      chk("t3_oor_drdy", {31'd0, data_ready}, 0);
      fire(16'h8003, 16'h77);
      chk("t3_drdy", {31'd0, data_ready}, 1);
      chk("t3_err_sticky", {31'd0, load_err}, 1);
      finish_tile();

      // T4: zero targets; load_start coinciding with compute_done ignored.
      start(0, 0);
      chk("t4_drdy_n1", {31'd0, data_ready}, 0);
      step();
      chk("t4_drdy_n2", {31'd0, data_ready}, 1);
      compute_done = 1'b1; load_start = 1'b1;
      step();
      compute_done = 1'b0; load_start = 1'b0;
      chk("t4_start_ignored", {30'd0, busy, data_ready}, 0);
      start(0, 0);
      chk("t4_start_accepted", {31'd0, busy}, 1);
      step();
      chk("t4_drdy_again", {31'd0, data_ready}, 1);
      finish_tile();

      // T5: reset mid-LOAD after 3 fires.
      start(4, 2);
      fire(16'h0000, 16'h0); fire(16'h0001, 16'h1); fire(16'h0002, 16'h2);
      arst_n_in = 1'b0;
      step();
      arst_n_in = 1'b1;
      chk("t5_rst_outputs", {28'd0, a_ready, busy, data_ready, load_err}, 0);
      clr_log();
      start(1, 1);
      fire(16'h0007, 16'h7);
      chk("t5_drdy_after1", {31'd0, data_ready}, 0);
      fire(16'h8002, 16'h8);
      chk("t5_drdy_after2", {31'd0, data_ready}, 1);
      finish_tile();

      // T6: extra input word while kernel still pending.
      clr_log();
      start(2, 1);
      fire(16'h0000, 16'h0); fire(16'h0001, 16'h1);
      fire(16'h0002, 16'h2);
      chk("t6_extra_err", {31'd0, load_err}, 1);
      chk("t6_extra_written", in_we_n, 3);
      chk("t6_extra_drdy", {31'd0, data_ready}, 0);
      fire(16'h8000, 16'h3);
      chk("t6_drdy", {31'd0, data_ready}, 1);
      finish_tile();

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
